vdp_host_bridge: RTL

VDP_HOST_BRIDGE -- requirements
Module: vdp_host_bridge

---
 rtl/vdp_pkg.sv | 15 +
 rtl/vdp_write_fifo.sv | 52 +++++
 rtl/vdp_host_bridge.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared VDP bridge widths and handshake state encoding
package vdp_pkg;

  localparam int VDP_ADDR_W  = 5;
  localparam int VDP_DATA_W  = 16;
  localparam int VDP_ENTRY_W = VDP_ADDR_W + VDP_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2,
    ST_ACK   = 2'd3
  } hs_state_e;

endpackage

// File: rtl/vdp_write_fifo.sv
// rtl/vdp_write_fifo.sv - posted host-write FIFO with same-cycle pop/push pass-through of the free slot
module vdp_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign do_pop    = pop & ~empty;
  // A pop frees its slot this cycle, so a push into a full FIFO may land alongside it.
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + COUNT_ONE;
      else if (do_pop && !do_push) count <= count - COUNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vdp_host_bridge.sv
// rtl/vdp_host_bridge.sv - CPU/copper to VDP register-file bridge with posted writes and ready handshake
module vdp_host_bridge
  import vdp_pkg::*;
#(
  parameter int USE_8BIT_BUS = 0,
  parameter int FIFO_DEPTH   = 4,
  parameter int WAIT_STATES  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            host_address,
  input  logic                  host_write_en,
  input  logic [15:0]           host_write_data,
  input  logic                  host_read_en,
  output logic                  ready,
  input  logic                  cop_write_en,
  input  logic [VDP_ADDR_W-1:0] cop_write_address,
  input  logic [15:0]           cop_write_data,
  output logic                  register_write_en,
  output logic [VDP_ADDR_W-1:0] register_write_address,
  output logic [15:0]           register_write_data,
  output logic [VDP_ADDR_W-1:0] read_address,
  output logic                  fifo_full
);

  localparam bit         BYTE_MODE = (USE_8BIT_BUS != 0);
  localparam logic [1:0] WAIT_LOAD = 2'(WAIT_STATES);

  hs_state_e state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic        wr_q, wr_prev, rd_q, rd_prev;
  logic [5:0]  addr_q;
  logic [15:0] data_q;
  logic        acc_write;
  logic [5:0]  acc_addr;
  logic [15:0] acc_data;
  logic [7:0]  low_byte;
  logic        wr_edge, rd_edge, access_edge;
  logic        needs_push, can_push, push, pop, latch_low, fifo_empty;
  logic [VDP_ENTRY_W-1:0] fifo_din, fifo_head;

  assign wr_edge     = wr_q & ~wr_prev;
  assign rd_edge     = rd_q & ~rd_prev;
  assign access_edge = wr_edge | rd_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q         <= 1'b0;
      wr_prev      <= 1'b0;
      rd_q         <= 1'b0;
      rd_prev      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      read_address <= '0;
    end else begin
      wr_q         <= host_write_en;
      wr_prev      <= wr_q;
      rd_q         <= host_read_en;
      rd_prev      <= rd_q;
      addr_q       <= host_address;
      data_q       <= host_write_data;
      read_address <= BYTE_MODE ? host_address[5:1] : host_address[4:0];
    end
  end

  // The access is frozen at its edge so a CPU that changes the bus early still posts what it strobed.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_write <= 1'b0;
      acc_addr  <= '0;
      acc_data  <= '0;
    end else if (state_q == ST_IDLE && access_edge) begin
      acc_write <= wr_edge;
      acc_addr  <= addr_q;
      acc_data  <= data_q;
    end
  end

  assign needs_push = acc_write & (~BYTE_MODE | acc_addr[0]);
  assign pop        = ~cop_write_en & ~fifo_empty;
  assign can_push   = ~fifo_full | pop;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    push      = 1'b0;
    latch_low = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_edge) begin
          state_d = ST_WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (wait_q != 2'd0) begin
          wait_d = wait_q - 2'd1;
        end else if (needs_push) begin
          if (can_push) begin
            push    = 1'b1;
            state_d = ST_ACK;
          end else begin
            state_d = ST_STALL;
          end
        end else begin
          latch_low = acc_write;
          state_d   = ST_ACK;
        end
      end
      ST_STALL: begin
        if (can_push) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign ready = (state_q == ST_ACK);

  always_comb begin
    fifo_din = '0;
    if (BYTE_MODE) fifo_din = {acc_addr[5:1], acc_data[7:0], low_byte};
    else           fifo_din = {acc_addr[4:0], acc_data};
  end

  always_ff @(posedge clk) begin
    if (reset)                  low_byte <= '0;
    else if (latch_low)         low_byte <= acc_data[7:0];
    else if (push && BYTE_MODE) low_byte <= '0;
  end

  // Copper has priority; its writes cannot be held off, so the FIFO only drains in copper gaps.
  always_ff @(posedge clk) begin
    if (reset) begin
      register_write_en      <= 1'b0;
      register_write_address <= '0;
      register_write_data    <= '0;
    end else begin
      register_write_en <= cop_write_en | pop;
      if (cop_write_en) begin
        register_write_address <= cop_write_address;
        register_write_data    <= cop_write_data;
      end else if (pop) begin
        register_write_address <= fifo_head[VDP_ENTRY_W-1:VDP_DATA_W];
        register_write_data    <= fifo_head[VDP_DATA_W-1:0];
      end
    end
  end

  vdp_write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (VDP_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (fifo_din),
    .pop       (pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && access_edge && state_q != ST_IDLE)
      $display("%m: host access ignored, handshake busy (protocol violation) at %0t", $time);
  end
`endif

endmodule
